// File: rtl/usbf_req_sched.sv
// hclk-domain round-robin scheduler for EP rd/wt request pulses toward the phyclk synchronisers.
// Optional: define USBF_REQ_SCHED_WT_PRIO_EN for two-tier arbitration (writes first).
module usbf_req_sched #(
  parameter int EP_NUM = 4,
  parameter int DATA_W = 32,
  parameter int LEAD   = 2,
  parameter int GAP    = 6
) (
  input  logic                     hclk_i,
  input  logic                     rst_i,
  input  logic [EP_NUM-1:0]        rd_req_i,
  input  logic [EP_NUM-1:0]        wt_req_i,
  input  logic [DATA_W*EP_NUM-1:0] wt_data_i,
  input  logic [EP_NUM-1:0]        flush_i,
  input  logic                     ovf_clr_i,
  output logic [EP_NUM-1:0]        rd_req_o,
  output logic [EP_NUM-1:0]        wt_req_o,
  output logic [DATA_W*EP_NUM-1:0] tx_data_o,
  output logic [2*EP_NUM-1:0]      pend_o,
  output logic                     busy_o,
  output logic [2*EP_NUM-1:0]      ovf_o
);

  localparam int SRC = 2 * EP_NUM;
  localparam int SW  = $clog2(SRC);
  localparam int EW  = (EP_NUM > 1) ? $clog2(EP_NUM) : 1;
  localparam int MX  = (LEAD > GAP) ? LEAD : GAP;
  localparam int CW  = $clog2(MX + 1);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ISSUE,
    GUARD
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [SW-1:0]       gnt_q, gnt_d;
  logic [SRC-1:0]      pend_q, pend_d;
  logic [SRC-1:0]      ovf_q, ovf_d;
  logic [EP_NUM-1:0]   rd_p_q, rd_p_d;
  logic [EP_NUM-1:0]   wt_p_q, wt_p_d;
  logic [DATA_W-1:0]   shadow_q [EP_NUM];
  logic [DATA_W-1:0]   shadow_d [EP_NUM];
  logic [DATA_W-1:0]   tx_q [EP_NUM];
  logic [DATA_W-1:0]   tx_d [EP_NUM];

`ifdef USBF_REQ_SCHED_WT_PRIO_EN
  logic [EW-1:0]       wptr_q, wptr_d;
  logic [EW-1:0]       rptr_q, rptr_d;
  logic [SW:0]         wpick;
  logic [SW:0]         rpick;
`else
  logic [SW-1:0]       rr_q, rr_d;
`endif

  logic [SRC-1:0]      req_all;
  logic [SRC-1:0]      flush_all;
  logic [SRC-1:0]      cand;
  logic [SRC-1:0]      clr;
  logic [SW:0]         pick;
  logic [EP_NUM-1:0]   gep_oh;
  logic                gnt_wt;
  int                  gep;
  int                  p;

  // First set bit of vec[base +: n] at or after ptr, cyclic; msb = found.
  function automatic logic [SW:0] rr_pick(
    input logic [SRC-1:0] vec,
    input int             base,
    input int             n,
    input int             ptr
  );
    logic [SW:0]    r;
    logic [SRC-1:0] sh;
    int             k;
    r = '0;
    for (int i = n - 1; i >= 0; i--) begin
      k = ptr + i;
      if (k >= n) k = k - n;
      sh = vec >> (base + k);
      if (sh[0]) r = {1'b1, SW'(base + k)};
    end
    return r;
  endfunction

  assign req_all   = {wt_req_i, rd_req_i};
  assign flush_all = {flush_i, flush_i};
  assign cand      = pend_q & ~flush_all;

  always_comb begin
    gnt_wt = (int'(gnt_q) >= EP_NUM);
    gep    = gnt_wt ? int'(gnt_q) - EP_NUM : int'(gnt_q);
    gep_oh = EP_NUM'(1) << gep;
  end

`ifdef USBF_REQ_SCHED_WT_PRIO_EN
  always_comb begin
    wpick = rr_pick(cand, EP_NUM, EP_NUM, int'(wptr_q));
    rpick = rr_pick(cand, 0, EP_NUM, int'(rptr_q));
    pick  = wpick[SW] ? wpick : rpick;
  end
`else
  always_comb begin
    pick = rr_pick(cand, 0, SRC, int'(rr_q));
  end
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    clr     = '0;
    rd_p_d  = '0;
    wt_p_d  = '0;
    p       = int'(pick[SW-1:0]);
    tx_d    = tx_q;
`ifdef USBF_REQ_SCHED_WT_PRIO_EN
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
`else
    rr_d    = rr_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (pick[SW]) begin
          gnt_d   = pick[SW-1:0];
          clr     = SRC'(1) << p;
          state_d = SETUP;
          cnt_d   = '0;
`ifdef USBF_REQ_SCHED_WT_PRIO_EN
          if (p >= EP_NUM) begin
            wptr_d = (p - EP_NUM + 1 >= EP_NUM) ? '0 : EW'(p - EP_NUM + 1);
          end else begin
            rptr_d = (p + 1 >= EP_NUM) ? '0 : EW'(p + 1);
          end
`else
          rr_d = (p + 1 >= SRC) ? '0 : SW'(p + 1);
`endif
          for (int e = 0; e < EP_NUM; e++) begin
            if (p == e + EP_NUM) tx_d[e] = shadow_q[e];
          end
        end
      end
      SETUP: begin
        // A flush of the granted EP aborts before any pulse leaves.
        if (|(flush_i & gep_oh)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CW'(LEAD - 1)) begin
          state_d = ISSUE;
          cnt_d   = '0;
          rd_p_d  = gnt_wt ? '0 : gep_oh;
          wt_p_d  = gnt_wt ? gep_oh : '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ISSUE: begin
        state_d = GUARD;
        cnt_d   = '0;
      end
      GUARD: begin
        if (cnt_q == CW'(GAP - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // A new request survives its own grant-clear; flush beats both.
  always_comb begin
    pend_d = ((pend_q & ~clr) | req_all) & ~flush_all;
    ovf_d  = ovf_clr_i ? '0 : ovf_q;
    ovf_d  = ovf_d | (req_all & pend_q & ~clr & ~flush_all);
    shadow_d = shadow_q;
    for (int e = 0; e < EP_NUM; e++) begin
      if (wt_req_i[e]) shadow_d[e] = wt_data_i[e*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge hclk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      gnt_q   <= '0;
      pend_q  <= '0;
      ovf_q   <= '0;
      rd_p_q  <= '0;
      wt_p_q  <= '0;
      for (int e = 0; e < EP_NUM; e++) begin
        shadow_q[e] <= '0;
        tx_q[e]     <= '0;
      end
`ifdef USBF_REQ_SCHED_WT_PRIO_EN
      wptr_q  <= '0;
      rptr_q  <= '0;
`else
      rr_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      gnt_q    <= gnt_d;
      pend_q   <= pend_d;
      ovf_q    <= ovf_d;
      rd_p_q   <= rd_p_d;
      wt_p_q   <= wt_p_d;
      shadow_q <= shadow_d;
      tx_q     <= tx_d;
`ifdef USBF_REQ_SCHED_WT_PRIO_EN
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
`else
      rr_q     <= rr_d;
`endif
    end
  end

  for (genvar g = 0; g < EP_NUM; g++) begin : g_tx
    assign tx_data_o[g*DATA_W +: DATA_W] = tx_q[g];
  end

  assign rd_req_o = rd_p_q;
  assign wt_req_o = wt_p_q;
  assign pend_o   = pend_q;
  assign busy_o   = (state_q != IDLE);
  assign ovf_o    = ovf_q;

endmodule
